// File: rtl/quiz_round_ctrl.sv
// rtl/quiz_round_ctrl.sv - two-player quiz round controller: joystick edge events, timed rounds, scoring
module quiz_round_ctrl #(
  parameter int NUM_Q        = 10,
  parameter int ROUND_CYCLES = 1000,
  parameter int PAUSE_CYCLES = 50,
  parameter int WIN_SCORE    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] joy_l,
  input  logic [3:0] joy_r,
  input  logic [3:0] ans,
  output logic [3:0] q_idx,
  output logic       q_adv,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [1:0] result,
  output logic       lock_l,
  output logic       lock_r,
  output logic [1:0] state,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int TMAX = (ROUND_CYCLES > PAUSE_CYCLES) ? ROUND_CYCLES : PAUSE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] ROUND_LOAD = TW'(ROUND_CYCLES - 1);
  localparam logic [TW-1:0] PAUSE_LOAD = TW'(PAUSE_CYCLES - 1);
  localparam logic [3:0]    LAST_Q     = 4'(NUM_Q - 1);
  localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ASK   = 2'b01,
    S_PAUSE = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  function automatic logic [3:0] decode(input logic [3:0] j);
    case (j)
      4'b1110: decode = 4'd1;
      4'b1101: decode = 4'd2;
      4'b1011: decode = 4'd3;
      4'b0111: decode = 4'd4;
      default: decode = 4'd0;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [3:0]      q_idx_q, q_idx_d;
  logic [3:0]      score_l_q, score_l_d, score_r_q, score_r_d;
  logic [1:0]      result_q, result_d;
  logic            lock_l_q, lock_l_d, lock_r_q, lock_r_d;
  logic            q_adv_q, q_adv_d;
  logic            prio_q, prio_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      joy_l_q, joy_r_q;
  logic            joy_vld_q;
  logic            rel_l_q, rel_l_d, rel_r_q, rel_r_d;

  logic [3:0]      ch_l, ch_r;
  logic            ev_l, ev_r, sel_l, sel_r, hit_l, hit_r;

  // A release only counts when it was sampled from the pins, so a direction
  // held through reset never produces an event until it is let go.
  always_comb begin
    ch_l    = decode(joy_l_q);
    ch_r    = decode(joy_r_q);
    rel_l_d = joy_vld_q && (ch_l == 4'd0);
    rel_r_d = joy_vld_q && (ch_r == 4'd0);
    ev_l    = (ch_l != 4'd0) && rel_l_q && !lock_l_q;
    ev_r    = (ch_r != 4'd0) && rel_r_q && !lock_r_q;
    sel_l   = ev_l && (!ev_r || !prio_q);
    sel_r   = ev_r && (!ev_l || prio_q);
    hit_l   = sel_l && (ch_l == ans);
    hit_r   = sel_r && (ch_r == ans);
  end

  always_comb begin
    state_d   = state_q;
    q_idx_d   = q_idx_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    result_d  = result_q;
    lock_l_d  = lock_l_q;
    lock_r_d  = lock_r_q;
    q_adv_d   = 1'b0;
    prio_d    = prio_q;
    timer_d   = timer_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_ASK;
          q_idx_d   = 4'd0;
          score_l_d = 4'd0;
          score_r_d = 4'd0;
          lock_l_d  = 1'b0;
          lock_r_d  = 1'b0;
          timer_d   = ROUND_LOAD;
          q_adv_d   = (state_q == S_DONE);
        end
      end
      S_ASK: begin
        timer_d = timer_q - 1'b1;
        if (ev_l && ev_r) prio_d = ~prio_q;
        if (sel_l && !hit_l) lock_l_d = 1'b1;
        if (sel_r && !hit_r) lock_r_d = 1'b1;
        // Correct answer beats the timeout, which beats the both-wrong outcome.
        if (hit_l || hit_r) begin
          result_d = hit_l ? 2'b01 : 2'b10;
          if (hit_l) score_l_d = (score_l_q == 4'd15) ? 4'd15 : score_l_q + 4'd1;
          if (hit_r) score_r_d = (score_r_q == 4'd15) ? 4'd15 : score_r_q + 4'd1;
          state_d  = S_PAUSE;
          timer_d  = PAUSE_LOAD;
        end else if (timer_q == '0) begin
          result_d = 2'b00;
          state_d  = S_PAUSE;
          timer_d  = PAUSE_LOAD;
        end else if ((sel_l && lock_r_q) || (sel_r && lock_l_q)) begin
          result_d = 2'b11;
          state_d  = S_PAUSE;
          timer_d  = PAUSE_LOAD;
        end
      end
      S_PAUSE: begin
        if (timer_q == '0) begin
          if (score_l_q >= WIN || score_r_q >= WIN || q_idx_q == LAST_Q) begin
            state_d = S_DONE;
          end else begin
            state_d  = S_ASK;
            q_idx_d  = q_idx_q + 4'd1;
            q_adv_d  = 1'b1;
            lock_l_d = 1'b0;
            lock_r_d = 1'b0;
            timer_d  = ROUND_LOAD;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      q_idx_q   <= 4'd0;
      score_l_q <= 4'd0;
      score_r_q <= 4'd0;
      result_q  <= 2'b00;
      lock_l_q  <= 1'b0;
      lock_r_q  <= 1'b0;
      q_adv_q   <= 1'b0;
      prio_q    <= 1'b0;
      timer_q   <= '0;
      joy_l_q   <= 4'b1111;
      joy_r_q   <= 4'b1111;
      joy_vld_q <= 1'b0;
      rel_l_q   <= 1'b0;
      rel_r_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_idx_q   <= q_idx_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      result_q  <= result_d;
      lock_l_q  <= lock_l_d;
      lock_r_q  <= lock_r_d;
      q_adv_q   <= q_adv_d;
      prio_q    <= prio_d;
      timer_q   <= timer_d;
      joy_l_q   <= joy_l;
      joy_r_q   <= joy_r;
      joy_vld_q <= 1'b1;
      rel_l_q   <= rel_l_d;
      rel_r_q   <= rel_r_d;
    end
  end

  assign q_idx     = q_idx_q;
  assign q_adv     = q_adv_q;
  assign score_l   = score_l_q;
  assign score_r   = score_r_q;
  assign result    = result_q;
  assign lock_l    = lock_l_q;
  assign lock_r    = lock_r_q;
  assign state     = state_q;
  assign game_over = (state_q == S_DONE);
  assign winner    = (state_q != S_DONE)       ? 2'b00 :
                     (score_l_q > score_r_q)   ? 2'b01 :
                     (score_r_q > score_l_q)   ? 2'b10 : 2'b11;

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// tb/tb_quiz_round_ctrl.sv - directed vector table plus randomized play against a game-rule model
module tb_quiz_round_ctrl;
  localparam int NUM_Q = 10, ROUND = 1000, PAUSE = 50, WIN = 5;
  localparam logic [3:0] N = 4'b1111;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [3:0] joy_l, joy_r, ans;
  logic [3:0] q_idx, score_l, score_r;
  logic       q_adv, lock_l, lock_r, game_over;
  logic [1:0] result, state, winner;

  always #5 clk = ~clk;

  quiz_round_ctrl #(.NUM_Q(NUM_Q), .ROUND_CYCLES(ROUND), .PAUSE_CYCLES(PAUSE), .WIN_SCORE(WIN)) dut (
    .clk(clk), .rst(rst), .start(start), .joy_l(joy_l), .joy_r(joy_r), .ans(ans),
    .q_idx(q_idx), .q_adv(q_adv), .score_l(score_l), .score_r(score_r), .result(result),
    .lock_l(lock_l), .lock_r(lock_r), .state(state), .game_over(game_over), .winner(winner)
  );

  int total = 0, bad = 0;
  int ans_tab[16];

  // Game-rule model: phase 0 idle, 1 ask, 2 pause, 3 done; m_left counts clocks left in phase.
  int m_ph = 0, m_left = 0, m_qi = 0, m_sl = 0, m_sr = 0, m_res = 0, m_adv = 0;
  bit m_lkl = 0, m_lkr = 0, m_prio = 0;
  int m_c1_l = 0, m_c2_l = 0, m_c1_r = 0, m_c2_r = 0, m_ns = 0;

  typedef struct {
    bit rst, start;
    logic [3:0] jl, jr;
    int n, st, qi, sl, sr, res, lkl, lkr, adv, win;
  } vec_t;
  vec_t vecs[$];

  function automatic int dec(input logic [3:0] j);
    case (j)
      4'b1110: return 1;
      4'b1101: return 2;
      4'b1011: return 3;
      4'b0111: return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [3:0] rand_joy();
    int r;
    logic [3:0] v;
    r = $urandom_range(0, 9);
    if (r < 5) return N;
    if (r < 9) begin
      v = 4'b0001 << $urandom_range(0, 3);
      return ~v;
    end
    v = 4'($urandom_range(0, 15));
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int pick;
    bit evl, evr, correct, both;
    if (rst) begin
      m_ph = 0; m_left = 0; m_qi = 0; m_sl = 0; m_sr = 0; m_res = 0; m_adv = 0;
      m_lkl = 0; m_lkr = 0; m_prio = 0;
      m_c1_l = 0; m_c2_l = 0; m_c1_r = 0; m_c2_r = 0; m_ns = 0;
      return;
    end
    evl = (m_ns >= 2) && (m_c2_l == 0) && (m_c1_l != 0) && !m_lkl;
    evr = (m_ns >= 2) && (m_c2_r == 0) && (m_c1_r != 0) && !m_lkr;
    m_adv = 0;
    case (m_ph)
      0, 3: if (start) begin
        m_adv = (m_ph == 3);
        m_ph = 1; m_qi = 0; m_sl = 0; m_sr = 0; m_lkl = 0; m_lkr = 0; m_left = ROUND;
      end
      1: begin
        pick = 0;
        if (evl && evr) begin
          pick = m_prio ? 2 : 1;
          m_prio = !m_prio;
        end else if (evl) pick = 1;
        else if (evr) pick = 2;
        correct = (pick == 1 && m_c1_l == int'(ans)) || (pick == 2 && m_c1_r == int'(ans));
        both = (pick == 1 && m_lkr) || (pick == 2 && m_lkl);
        if (pick == 1 && !correct) m_lkl = 1;
        if (pick == 2 && !correct) m_lkr = 1;
        if (correct) begin
          if (pick == 1) m_sl = (m_sl < 15) ? m_sl + 1 : 15;
          else m_sr = (m_sr < 15) ? m_sr + 1 : 15;
          m_res = pick; m_ph = 2; m_left = PAUSE;
        end else if (m_left == 1) begin
          m_res = 0; m_ph = 2; m_left = PAUSE;
        end else if (both) begin
          m_res = 3; m_ph = 2; m_left = PAUSE;
        end else begin
          m_left--;
        end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin
          if (m_sl >= WIN || m_sr >= WIN || m_qi == NUM_Q - 1) m_ph = 3;
          else begin
            m_qi++; m_adv = 1; m_lkl = 0; m_lkr = 0; m_ph = 1; m_left = ROUND;
          end
        end
      end
    endcase
    m_c2_l = m_c1_l; m_c1_l = dec(joy_l);
    m_c2_r = m_c1_r; m_c1_r = dec(joy_r);
    if (m_ns < 2) m_ns++;
  endtask

  task automatic check_model();
    int w;
    w = (m_ph != 3) ? 0 : (m_sl > m_sr) ? 1 : (m_sr > m_sl) ? 2 : 3;
    check("state", state, m_ph);
    check("q_idx", q_idx, m_qi);
    check("q_adv", q_adv, m_adv);
    check("score_l", score_l, m_sl);
    check("score_r", score_r, m_sr);
    check("result", result, m_res);
    check("lock_l", lock_l, m_lkl);
    check("lock_r", lock_r, m_lkr);
    check("game_over", game_over, m_ph == 3);
    check("winner", winner, w);
  endtask

  task automatic cycle();
    ans = 4'(ans_tab[m_qi]);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  function automatic void add(bit r, bit s, logic [3:0] jl, logic [3:0] jr, int n, int st, int qi,
                              int sl, int sr, int res, int lkl, int lkr, int adv, int win);
    vec_t v;
    v.rst = r; v.start = s; v.jl = jl; v.jr = jr; v.n = n; v.st = st; v.qi = qi;
    v.sl = sl; v.sr = sr; v.res = res; v.lkl = lkl; v.lkr = lkr; v.adv = adv; v.win = win;
    vecs.push_back(v);
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) ans_tab[i] = (i % 4) + 1;
    //   rst st  jl       jr       n    st qi sl sr res lkl lkr adv win
    add(1, 0, N,       N,       2,   0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, N,       N,       3,   0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, N,       N,       1,   1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 4'b1110, N,       1,   1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 4'b1110, N,       1,   2, 0, 1, 0, 1, 0, 0, 0, 0);
    add(0, 0, 4'b1110, N,       1,   2, 0, 1, 0, 1, 0, 0, 0, 0);
    add(0, 0, N,       N,       48,  2, 0, 1, 0, 1, 0, 0, 0, 0);
    add(0, 0, N,       N,       1,   1, 1, 1, 0, 1, 0, 0, 1, 0);
    add(0, 0, N,       N,       1,   1, 1, 1, 0, 1, 0, 0, 0, 0);
    add(0, 0, N,       4'b0111, 2,   1, 1, 1, 0, 1, 0, 1, 0, 0);
    add(0, 0, 4'b1110, N,       2,   2, 1, 1, 0, 3, 1, 1, 0, 0);
    add(0, 0, N,       N,       49,  2, 1, 1, 0, 3, 1, 1, 0, 0);
    add(0, 0, N,       N,       1,   1, 2, 1, 0, 3, 0, 0, 1, 0);
    add(0, 0, 4'b1011, 4'b1011, 2,   2, 2, 2, 0, 1, 0, 0, 0, 0);
    add(0, 0, N,       N,       49,  2, 2, 2, 0, 1, 0, 0, 0, 0);
    add(0, 0, N,       N,       1,   1, 3, 2, 0, 1, 0, 0, 1, 0);
    add(0, 0, 4'b0111, 4'b0111, 2,   2, 3, 2, 1, 2, 0, 0, 0, 0);
    add(0, 0, N,       N,       49,  2, 3, 2, 1, 2, 0, 0, 0, 0);
    add(0, 0, N,       N,       1,   1, 4, 2, 1, 2, 0, 0, 1, 0);
    add(0, 0, N,       N,       999, 1, 4, 2, 1, 2, 0, 0, 0, 0);
    add(0, 0, N,       N,       1,   2, 4, 2, 1, 0, 0, 0, 0, 0);
    add(0, 0, N,       N,       49,  2, 4, 2, 1, 0, 0, 0, 0, 0);
    add(0, 0, N,       N,       1,   1, 5, 2, 1, 0, 0, 0, 1, 0);
    add(0, 0, N,       N,       998, 1, 5, 2, 1, 0, 0, 0, 0, 0);
    add(0, 0, 4'b1101, N,       1,   1, 5, 2, 1, 0, 0, 0, 0, 0);
    add(0, 0, 4'b1101, N,       1,   2, 5, 3, 1, 1, 0, 0, 0, 0);
    add(0, 0, N,       N,       49,  2, 5, 3, 1, 1, 0, 0, 0, 0);
    add(0, 0, N,       N,       1,   1, 6, 3, 1, 1, 0, 0, 1, 0);
    add(0, 0, 4'b1011, N,       2,   2, 6, 4, 1, 1, 0, 0, 0, 0);
    add(0, 0, N,       N,       49,  2, 6, 4, 1, 1, 0, 0, 0, 0);
    add(0, 0, N,       N,       1,   1, 7, 4, 1, 1, 0, 0, 1, 0);
    add(0, 0, 4'b0111, N,       2,   2, 7, 5, 1, 1, 0, 0, 0, 0);
    add(0, 0, N,       N,       49,  2, 7, 5, 1, 1, 0, 0, 0, 0);
    add(0, 0, N,       N,       1,   3, 7, 5, 1, 1, 0, 0, 0, 1);
    add(0, 1, N,       N,       1,   1, 0, 0, 0, 1, 0, 0, 1, 0);
    add(0, 0, N,       4'b1110, 2,   2, 0, 0, 1, 2, 0, 0, 0, 0);
    add(0, 0, N,       N,       49,  2, 0, 0, 1, 2, 0, 0, 0, 0);
    add(0, 0, N,       N,       1,   1, 1, 0, 1, 2, 0, 0, 1, 0);
    add(0, 0, N,       4'b1101, 2,   2, 1, 0, 2, 2, 0, 0, 0, 0);
    add(0, 0, N,       N,       49,  2, 1, 0, 2, 2, 0, 0, 0, 0);
    add(0, 0, N,       N,       1,   1, 2, 0, 2, 2, 0, 0, 1, 0);
    add(0, 0, N,       4'b1011, 2,   2, 2, 0, 3, 2, 0, 0, 0, 0);
    add(0, 0, 4'b1110, N,       10,  2, 2, 0, 3, 2, 0, 0, 0, 0);
    add(1, 0, 4'b1110, N,       1,   0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 4'b1110, N,       1,   1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 4'b1110, N,       5,   1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, N,       N,       2,   1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 4'b1110, N,       2,   2, 0, 1, 0, 1, 0, 0, 0, 0);

    rst = 1'b1; start = 1'b0; joy_l = N; joy_r = N; ans = 4'd1;
    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; start = vecs[i].start; joy_l = vecs[i].jl; joy_r = vecs[i].jr;
      for (int k = 0; k < vecs[i].n; k++) cycle();
      check($sformatf("v%0d_state", i), state, vecs[i].st);
      check($sformatf("v%0d_q_idx", i), q_idx, vecs[i].qi);
      check($sformatf("v%0d_score_l", i), score_l, vecs[i].sl);
      check($sformatf("v%0d_score_r", i), score_r, vecs[i].sr);
      check($sformatf("v%0d_result", i), result, vecs[i].res);
      check($sformatf("v%0d_lock_l", i), lock_l, vecs[i].lkl);
      check($sformatf("v%0d_lock_r", i), lock_r, vecs[i].lkr);
      check($sformatf("v%0d_q_adv", i), q_adv, vecs[i].adv);
      check($sformatf("v%0d_winner", i), winner, vecs[i].win);
    end

    for (int c = 0; c < 20000; c++) begin
      rst = ($urandom_range(0, 1999) == 0);
      start = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 2) == 0) joy_l = rand_joy();
      if ($urandom_range(0, 2) == 0) joy_r = rand_joy();
      if (m_ph == 0 || m_ph == 3)
        for (int i = 0; i < 16; i++) ans_tab[i] = $urandom_range(1, 4);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
